// File: rtl/register_addr_burst_if.sv
// Bus bundle for the burst-capable address register: control strobes,
// transfer bus in, address/status out and the bus-driver enables.
interface register_addr_burst_if #(
  parameter int WIDTH       = 16,
  parameter int STEP_WIDTH  = 4,
  parameter int COUNT_WIDTH = 8
);
  logic [WIDTH-1:0]       xfer_in;
  logic                   load_xfer;
  logic                   load_step;
  logic                   inc;
  logic                   dec;
  logic                   burst_start;
  logic                   burst_down;
  logic                   beat;
  logic                   assert_addr;
  logic                   assert_xfer;
  logic [WIDTH-1:0]       addr_out;
  logic [WIDTH-1:0]       xfer_out;
  logic                   addr_en;
  logic                   xfer_en;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   overflow;

  // Controller side: drives the strobes, observes the register.
  modport master (
    output xfer_in, load_xfer, load_step, inc, dec, burst_start, burst_down,
           beat, assert_addr, assert_xfer,
    input  addr_out, xfer_out, addr_en, xfer_en, busy, done, remaining, overflow
  );

  // Register side.
  modport slave (
    input  xfer_in, load_xfer, load_step, inc, dec, burst_start, burst_down,
           beat, assert_addr, assert_xfer,
    output addr_out, xfer_out, addr_en, xfer_en, busy, done, remaining, overflow
  );
endinterface

// File: rtl/register_addr_burst.sv
// Address register with programmable step, wrap/saturate arithmetic with a
// sticky overflow flag, and a beat-driven burst engine. All state moves on
// the falling edge of clk; control strobes are active-low.
module register_addr_burst #(
  parameter int               WIDTH         = 16,
  parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter int               STEP_WIDTH    = 4,
  parameter int               COUNT_WIDTH   = 8,
  parameter bit               SATURATE      = 1'b0
) (
  input logic                   clk,
  input logic                   reset,
  register_addr_burst_if.slave  bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       addr;
  logic [STEP_WIDTH-1:0]  step;
  logic                   dir;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  logic [WIDTH:0]         up_res;
  logic [WIDTH:0]         dn_res;
  logic [WIDTH:0]         beat_res;
  logic [COUNT_WIDTH-1:0] start_count;

  // Returns {crossed, next_address}. The step is zero-extended and the sum is
  // formed one bit wider so the top bit is the carry (up) or borrow (down).
  function automatic logic [WIDTH:0] step_addr(input logic [WIDTH-1:0]      a,
                                               input logic [STEP_WIDTH-1:0] s,
                                               input logic                  down);
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] res;
    ext = (WIDTH+1)'(s);
    raw = down ? ({1'b0, a} - ext) : ({1'b0, a} + ext);
    res = raw[WIDTH-1:0];
    if (raw[WIDTH] && SATURATE)
      res = down ? '0 : '1;
    return {raw[WIDTH], res};
  endfunction

  assign up_res      = step_addr(addr, step, 1'b0);
  assign dn_res      = step_addr(addr, step, 1'b1);
  assign beat_res    = dir ? dn_res : up_res;
  assign start_count = bus.xfer_in[COUNT_WIDTH-1:0];

  // Address, step, burst state and flags; one action per falling edge.
  always_ff @(negedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= DEFAULT_VALUE;
      step      <= STEP_WIDTH'(1);
      dir       <= 1'b0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.load_xfer) begin
            addr     <= bus.xfer_in;
            overflow <= 1'b0;
          end else if (!bus.load_step) begin
            step <= bus.xfer_in[STEP_WIDTH-1:0];
          end else if (!bus.burst_start) begin
            if (start_count == '0) begin
              done <= 1'b1;
            end else begin
              state     <= BURST;
              remaining <= start_count;
              dir       <= bus.burst_down;
              busy      <= 1'b1;
            end
          end else if (!bus.inc) begin
            addr     <= up_res[WIDTH-1:0];
            overflow <= overflow | up_res[WIDTH];
          end else if (!bus.dec) begin
            addr     <= dn_res[WIDTH-1:0];
            overflow <= overflow | dn_res[WIDTH];
          end
        end
        BURST: begin
          if (!bus.load_xfer) begin
            state     <= IDLE;
            addr      <= bus.xfer_in;
            overflow  <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
          end else if (!bus.beat) begin
            addr      <= beat_res[WIDTH-1:0];
            overflow  <= overflow | beat_res[WIDTH];
            remaining <= remaining - COUNT_WIDTH'(1);
            if (remaining == COUNT_WIDTH'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr_out  = addr;
  assign bus.xfer_out  = addr;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.remaining = remaining;
  assign bus.overflow  = overflow;
  assign bus.addr_en   = ~bus.assert_addr;
  assign bus.xfer_en   = ~bus.assert_xfer;

endmodule

// File: tb/tb_register_addr_burst.sv
// Bench for register_addr_burst: a wrap-mode and a saturate-mode instance are
// driven with identical stimulus; expected responses from an arithmetic
// reference model are queued and checked by an independent monitor.
module tb_register_addr_burst;

  localparam longint MAXV = 64'd65535;

  logic        clk;
  logic        reset;
  logic [15:0] xfer_in;
  logic        load_xfer, load_step, inc, dec, burst_start, burst_down, beat;
  logic        assert_addr, assert_xfer;

  register_addr_burst_if #(.WIDTH(16), .STEP_WIDTH(4), .COUNT_WIDTH(8)) bw ();
  register_addr_burst_if #(.WIDTH(16), .STEP_WIDTH(4), .COUNT_WIDTH(8)) bs ();

  assign bw.xfer_in = xfer_in;         assign bs.xfer_in = xfer_in;
  assign bw.load_xfer = load_xfer;     assign bs.load_xfer = load_xfer;
  assign bw.load_step = load_step;     assign bs.load_step = load_step;
  assign bw.inc = inc;                 assign bs.inc = inc;
  assign bw.dec = dec;                 assign bs.dec = dec;
  assign bw.burst_start = burst_start; assign bs.burst_start = burst_start;
  assign bw.burst_down = burst_down;   assign bs.burst_down = burst_down;
  assign bw.beat = beat;               assign bs.beat = beat;
  assign bw.assert_addr = assert_addr; assign bs.assert_addr = assert_addr;
  assign bw.assert_xfer = assert_xfer; assign bs.assert_xfer = assert_xfer;

  register_addr_burst #(.WIDTH(16), .DEFAULT_VALUE(16'h0100), .STEP_WIDTH(4),
                        .COUNT_WIDTH(8), .SATURATE(1'b0))
    dut_wrap (.clk(clk), .reset(reset), .bus(bw.slave));

  register_addr_burst #(.WIDTH(16), .DEFAULT_VALUE(16'h0100), .STEP_WIDTH(4),
                        .COUNT_WIDTH(8), .SATURATE(1'b1))
    dut_sat (.clk(clk), .reset(reset), .bus(bs.slave));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    longint addr;
    int     step;
    bit     ovf;
    int     rem;
    bit     dir;
    bit     done;
  } model_t;

  typedef struct {
    model_t w;
    model_t s;
    bit     aen;
    bit     xen;
  } exp_t;

  exp_t   expq[$];
  model_t mw, ms;
  int     total = 0;
  int     bad   = 0;

  // Moves the address one step; out-of-range results wrap or clamp.
  function automatic model_t move(model_t m, bit down, bit sat);
    model_t n = m;
    longint t = down ? m.addr - m.step : m.addr + m.step;
    if (t < 0 || t > MAXV) begin
      n.ovf = 1'b1;
      if (sat) t = down ? 0 : MAXV;
      else     t = down ? t + 65536 : t - 65536;
    end
    n.addr = t;
    return n;
  endfunction

  // Next visible state from the current inputs; a burst is "in progress"
  // exactly when beats remain.
  function automatic model_t mstep(model_t m, bit sat);
    model_t n = m;
    n.done = 1'b0;
    if (reset) begin
      n.addr = 64'h0100; n.step = 1; n.ovf = 0; n.rem = 0; n.dir = 0;
      return n;
    end
    if (n.rem == 0) begin
      if (!load_xfer) begin
        n.addr = xfer_in; n.ovf = 0;
      end else if (!load_step) begin
        n.step = xfer_in % 16;
      end else if (!burst_start) begin
        if (xfer_in % 256 == 0) n.done = 1'b1;
        else begin n.rem = xfer_in % 256; n.dir = burst_down; end
      end else if (!inc) begin
        n = move(n, 1'b0, sat);
      end else if (!dec) begin
        n = move(n, 1'b1, sat);
      end
    end else begin
      if (!load_xfer) begin
        n.addr = xfer_in; n.ovf = 0; n.rem = 0;
      end else if (!beat) begin
        n = move(n, n.dir, sat);
        n.rem = n.rem - 1;
        if (n.rem == 0) n.done = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs settle at the falling edge; sample at the rising edge.
  always @(posedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("wrap_addr",  longint'(bw.addr_out),  e.w.addr);
      chk("wrap_xfer",  longint'(bw.xfer_out),  e.w.addr);
      chk("wrap_busy",  longint'(bw.busy),      longint'(e.w.rem != 0));
      chk("wrap_done",  longint'(bw.done),      longint'(e.w.done));
      chk("wrap_rem",   longint'(bw.remaining), longint'(e.w.rem));
      chk("wrap_ovf",   longint'(bw.overflow),  longint'(e.w.ovf));
      chk("sat_addr",   longint'(bs.addr_out),  e.s.addr);
      chk("sat_busy",   longint'(bs.busy),      longint'(e.s.rem != 0));
      chk("sat_done",   longint'(bs.done),      longint'(e.s.done));
      chk("sat_rem",    longint'(bs.remaining), longint'(e.s.rem));
      chk("sat_ovf",    longint'(bs.overflow),  longint'(e.s.ovf));
      chk("addr_en",    longint'(bw.addr_en),   longint'(e.aen));
      chk("xfer_en",    longint'(bs.xfer_en),   longint'(e.xen));
    end
  end

  // Drives one period of inputs, advances the models and queues the result.
  task automatic cyc_raw(input bit rs, input bit lx, input bit ls, input bit ic,
                         input bit dc, input bit bst, input bit bd, input bit bt,
                         input logic [15:0] x, input bit aa, input bit ax);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; load_xfer = lx; load_step = ls; inc = ic; dec = dc;
    burst_start = bst; burst_down = bd; beat = bt; xfer_in = x;
    assert_addr = aa; assert_xfer = ax;
    mw = mstep(mw, 1'b0);
    ms = mstep(ms, 1'b1);
    e.w = mw; e.s = ms; e.aen = ~aa; e.xen = ~ax;
    expq.push_back(e);
  endtask

  localparam int NOP = 0, RST = 1, LX = 2, LS = 3, INC = 4, DEC = 5,
                 BSU = 6, BSD = 7, BT = 8, INCDEC = 9;

  task automatic cyc(input int op, input logic [15:0] x);
    cyc_raw(op == RST, op != LX, op != LS, !(op == INC || op == INCDEC),
            !(op == DEC || op == INCDEC), !(op == BSU || op == BSD), op == BSD,
            op != BT, x, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; load_xfer = 1'b1; load_step = 1'b1; inc = 1'b1; dec = 1'b1;
    burst_start = 1'b1; burst_down = 1'b0; beat = 1'b1; xfer_in = '0;
    assert_addr = 1'b1; assert_xfer = 1'b1;
    mw = '{64'h0100, 1, 0, 0, 0, 0};
    ms = mw;

    // Reset, unit step inc/dec
    cyc(RST, 0); cyc(RST, 0); cyc(NOP, 0);
    cyc(INC, 0); cyc(DEC, 0); cyc(DEC, 0);
    // Step 4, wrap/clamp at both ends, overflow clear on load
    cyc(LS, 4); cyc(LX, 16'h0010); cyc(INC, 0);
    cyc(LX, 16'hFFFE); cyc(INC, 0); cyc(NOP, 0); cyc(LX, 16'h0000);
    cyc(LX, 16'h0002); cyc(DEC, 0); cyc(LX, 16'hFFFD); cyc(INC, 0);
    cyc(LS, 0); cyc(INC, 0); cyc(DEC, 0);
    // Three-beat up burst with step 2
    cyc(LS, 2); cyc(LX, 16'h1000); cyc(BSU, 3);
    cyc(BT, 0); cyc(BT, 0); cyc(BT, 0); cyc(NOP, 0); cyc(BT, 0);
    // Aborted down burst, zero-count burst
    cyc(LS, 1); cyc(LX, 16'h0004); cyc(BSD, 5); cyc(BT, 0); cyc(BT, 0);
    cyc(LX, 16'h2000); cyc(NOP, 0); cyc(BSU, 16'hAB00); cyc(NOP, 0);
    // Down burst through zero, reset mid-burst, inc+dec, inc ignored in burst
    cyc(LX, 16'h0001); cyc(BSD, 3); cyc(BT, 0); cyc(BT, 0); cyc(BT, 0);
    cyc(BSU, 4); cyc(BT, 0); cyc(RST, 0); cyc(NOP, 0);
    cyc(INCDEC, 0); cyc(BSU, 2); cyc(INC, 0); cyc(LS, 7); cyc(BT, 0);
    cyc(BT, 0); cyc(NOP, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] x;
      x = 16'($urandom);
      if ($urandom_range(0, 1) == 1) x = 16'($urandom_range(0, 6));
      cyc_raw($urandom_range(0, 63) == 0,
              $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 4) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
              x, 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_addr_burst.md
# register_addr_burst

Parametrised address register, successor to the basic inc/dec/load address register. Adds a programmable step size, selectable wrap or saturate arithmetic with a sticky overflow flag, and a burst engine. The burst engine advances the address by one step per beat strobe for a loaded beat count and reports busy/done. It sits on the address and transfer buses like the other address registers (PC, SP, memory pointers); bus drivers use the enable outputs.

## Interface
Parameters:
- WIDTH, 16, address/bus width in bits
- DEFAULT_VALUE, 0, value loaded at power-up and by reset
- STEP_WIDTH, 4, width of the step register
- COUNT_WIDTH, 8, width of the burst beat counter
- SATURATE, 0, 0 = modular wrap; 1 = clamp at 0 / all-ones

Ports:
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  synchronous, active-high; sampled at the falling edge of clk
- xfer_in  in  WIDTH  transfer bus input
- load_xfer  in  1  active-low; load address from xfer_in
- load_step  in  1  active-low; load step from xfer_in[STEP_WIDTH-1:0]
- inc  in  1  active-low; address += step
- dec  in  1  active-low; address -= step
- burst_start  in  1  active-low; load beat count from xfer_in[COUNT_WIDTH-1:0] and start a burst
- burst_down  in  1  burst direction, sampled with burst_start: 0 = up, 1 = down
- beat  in  1  active-low; one burst beat
- assert_addr, assert_xfer  in  1  active-low bus assert requests
- addr_out, xfer_out  out  WIDTH  current address; always driven
- addr_en, xfer_en  out  1  ~assert_addr, ~assert_xfer; combinational and independent of reset
- busy  out  1  high while in BURST
- done  out  1  one-cycle pulse when a burst completes
- remaining  out  COUNT_WIDTH  beats left in the current burst
- overflow  out  1  sticky; an add/subtract crossed the address range

## Operation
- Reset values: address = DEFAULT_VALUE, step = 1, busy = 0, done = 0, remaining = 0, overflow = 0, direction = up, state = IDLE.
- Arithmetic: the step is zero-extended to WIDTH and computed at WIDTH+1 bits to detect carry/borrow.
  - SATURATE = 0: result is taken modulo 2^WIDTH; overflow sets on wrap.
  - SATURATE = 1: result clamps to all-ones (up) or 0 (down); overflow sets on clamp.
- Overflow clears only on reset or load_xfer. A step of 0 is legal: the address holds and no overflow occurs.
- IDLE priority (one action per edge): reset > load_xfer > load_step > burst_start > inc > dec.
  - inc and dec asserted together: inc wins.
  - burst_start with count 0: stays in IDLE, done pulses, address unchanged.
  - burst_start with count N > 0: enters BURST with remaining = N, direction latched from burst_down, busy = 1. The address does not move on the start edge.
- BURST priority: reset > load_xfer > beat.
  - Each beat moves the address one step in the latched direction and decrements remaining.
  - The beat that takes remaining from 1 to 0 returns the state to IDLE, clears busy, and pulses done.
  - load_xfer aborts the burst: loads the address, clears overflow, sets remaining = 0, busy = 0, no done pulse.
  - inc, dec, load_step and burst_start are ignored in BURST.
  - In saturate mode, beats after a clamp still count down; the address stays clamped.
- Reset mid-burst: returns to the reset values on that edge; no done pulse.
- done is high only for the single clk period after the completing edge and is cleared by any other edge.

## Timing
- All registered outputs (addr_out, xfer_out, busy, done, remaining, overflow) change only at the falling edge of clk. They are valid for the full following period.
- Controls must be stable around the falling edge. There is no input registering; the effect is visible immediately after the sampling edge (latency 0 cycles after the edge).
- A beat is counted on every falling edge where beat is low. Consecutive beats on back-to-back edges are supported, so an N-beat burst completes in N edges after the start edge.
- addr_en and xfer_en are purely combinational and have no clock dependency.

## Test plan
- Reset with DEFAULT_VALUE = 16'h0100 -> addr_out = 0100, step = 1, busy = 0, overflow = 0; inc -> 0101; dec twice -> 00FF.
- load_step with xfer_in = 4 then inc from 0x0010 -> 0x0014. Wrap mode: load FFFE, inc -> 0002, overflow = 1; load_xfer 0 -> overflow = 0.
- SATURATE = 1, step 4: load 0002, dec -> 0000, overflow = 1. Load FFFD, inc -> FFFF.
- burst_start count 3, up, step 2, from 0x1000; three consecutive beats -> 1002, 1004, 1006. busy high for 3 periods, remaining 3→2→1→0, done high one period after the third beat.
- Burst count 5, down, from 0x0004, step 1; load_xfer = 0x2000 after 2 beats -> address 2000, busy = 0, no done. burst_start count 0 -> done pulses, address unchanged.
- Mid-burst reset -> reset values, no done; inc+dec together in IDLE -> increments; inc during BURST -> ignored.
